switch_debounce: RTL and testbench



---
 rtl/switch_debounce.sv | 111 +++++++++++
 tb/tb_switch_debounce.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module   : switch_debounce
// Brief    : Two-flop synchroniser plus shared-tick debouncer for slide
//            switches; publishes clean level, rise/fall pulses and zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module switch_debounce #(
    parameter int          WIDTH          = 8,
    parameter logic [23:0] SAMPLE_DIV     = 24'd10_000,
    parameter int          STABLE_SAMPLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed,
    output logic             sw_is_zero,
    output logic             sample_tick
);

    localparam logic [23:0] c_DIV_LAST = SAMPLE_DIV - 24'd1;
    localparam logic [3:0]  c_CNT_LAST = 4'(STABLE_SAMPLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [23:0]      r_div;
    logic             r_tick;
    logic [3:0]       r_cnt [WIDTH];
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_changed;
    logic             r_zero;
    logic [WIDTH-1:0] w_next_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_s1   <= sw_in;
            r_s2   <= r_s1;
            r_tick <= (r_div == c_DIV_LAST);
            r_div  <= (r_div == c_DIV_LAST) ? 24'd0 : r_div + 24'd1;
        end
    end

    // Each bit counts consecutive differing ticks; any agreeing tick restarts it.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [3:0] w_cnt_nxt;
            logic       w_out_nxt;

            always_comb begin
                w_cnt_nxt = r_cnt[i];
                w_out_nxt = r_out[i];
                if (r_tick) begin
                    if (r_s2[i] == r_out[i]) begin
                        w_cnt_nxt = 4'd0;
                    end else if (r_cnt[i] == c_CNT_LAST) begin
                        w_out_nxt = r_s2[i];
                        w_cnt_nxt = 4'd0;
                    end else begin
                        w_cnt_nxt = r_cnt[i] + 4'd1;
                    end
                end
            end

            assign w_next_out[i] = w_out_nxt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt[i] <= 4'd0;
                end else begin
                    r_cnt[i] <= w_cnt_nxt;
                end
            end
        end
    endgenerate

    // Pulses and zero flag derive from the next level so they land with sw_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out     <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
            r_zero    <= 1'b1;
        end else begin
            r_out     <= w_next_out;
            r_rise    <= w_next_out & ~r_out;
            r_fall    <= ~w_next_out & r_out;
            r_changed <= |(w_next_out ^ r_out);
            r_zero    <= (w_next_out == '0);
        end
    end

    assign sw_out      = r_out;
    assign sw_rise     = r_rise;
    assign sw_fall     = r_fall;
    assign changed     = r_changed;
    assign sw_is_zero  = r_zero;
    assign sample_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debounce
// Brief    : Bench for switch_debounce: vector table, corner sequences and
//            randomized stimulus against a sample-window reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debounce;

    localparam int DIV  = 4;
    localparam int STAB = 3;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic [7:0] sw_a = 8'h00;
    logic [7:0] out_a, rise_a, fall_a;
    logic       chg_a, zero_a, tick_a;
    logic       rst_b = 1'b1;
    logic [7:0] sw_b = 8'h00;
    logic [7:0] out_b, rise_b, fall_b;
    logic       chg_b, zero_b, tick_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    switch_debounce #(.WIDTH(8), .SAMPLE_DIV(24'd4), .STABLE_SAMPLES(3)) u_dut_a (
        .clk(clk), .reset(rst_a), .sw_in(sw_a), .sw_out(out_a), .sw_rise(rise_a),
        .sw_fall(fall_a), .changed(chg_a), .sw_is_zero(zero_a), .sample_tick(tick_a)
    );

    switch_debounce #(.WIDTH(8), .SAMPLE_DIV(24'd1), .STABLE_SAMPLES(1)) u_dut_b (
        .clk(clk), .reset(rst_b), .sw_in(sw_b), .sw_out(out_b), .sw_rise(rise_b),
        .sw_fall(fall_b), .changed(chg_b), .sw_is_zero(zero_b), .sample_tick(tick_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bit flips once the last STAB tick samples taken since
    // its previous flip (or reset) all disagree with its current level.
    int         m_n;
    logic [7:0] q0, q1;
    logic [7:0] m_out, m_rise, m_fall;
    logic       m_chg, m_zero, m_tick;
    logic       m_valid = 1'b0;
    logic [7:0] ts[$];
    int         last_acc[8];

    always @(posedge clk) begin
        logic [7:0] s2;
        logic [7:0] nxt;
        int         t;
        logic       ok;
        if (rst_a) begin
            m_n = 0; q0 = '0; q1 = '0;
            m_out = '0; m_rise = '0; m_fall = '0;
            m_chg = 1'b0; m_zero = 1'b1; m_tick = 1'b0;
            ts.delete();
            for (int i = 0; i < 8; i++) last_acc[i] = 0;
            m_valid = 1'b1;
        end else begin
            s2 = q0; q0 = q1; q1 = sw_a;
            m_rise = '0; m_fall = '0;
            if (m_tick) begin
                ts.push_back(s2);
                t = ts.size();
                nxt = m_out;
                for (int i = 0; i < 8; i++) begin
                    if (t - last_acc[i] >= STAB) begin
                        ok = 1'b1;
                        for (int k = 0; k < STAB; k++)
                            if (ts[t-1-k][i] == m_out[i]) ok = 1'b0;
                        if (ok) begin
                            nxt[i] = ~m_out[i];
                            last_acc[i] = t;
                        end
                    end
                end
                m_rise = nxt & ~m_out;
                m_fall = ~nxt & m_out;
                m_out = nxt;
            end
            m_chg  = |(m_rise | m_fall);
            m_zero = (m_out == 8'h00);
            m_n++;
            m_tick = (m_n % DIV == 0);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_sw_out", 32'(out_a), 32'(m_out));
            check("model_sw_rise", 32'(rise_a), 32'(m_rise));
            check("model_sw_fall", 32'(fall_a), 32'(m_fall));
            check("model_changed", 32'(chg_a), 32'(m_chg));
            check("model_sw_is_zero", 32'(zero_a), 32'(m_zero));
            check("model_sample_tick", 32'(tick_a), 32'(m_tick));
        end
    end

    typedef struct {
        logic       rst;
        logic [7:0] sw;
        int         cycles;
        logic [7:0] exp_out;
        logic [7:0] exp_rise;
        logic [7:0] exp_fall;
        int         exp_chg;
        int         exp_ticks;
        logic       exp_zero;
    } vec_t;

    initial begin
        vec_t       vt[9];
        logic [7:0] acc_r, acc_f, prev, v;
        int         n_chg, n_tick, e, nt, cyc, hold;

        vt[0] = '{1'b1, 8'h00,  2, 8'h00, 8'h00, 8'h00, 0, 0, 1'b1};
        vt[1] = '{1'b0, 8'h00, 20, 8'h00, 8'h00, 8'h00, 0, 5, 1'b1};
        vt[2] = '{1'b0, 8'hA5, 20, 8'hA5, 8'hA5, 8'h00, 1, 5, 1'b0};
        vt[3] = '{1'b0, 8'h5A, 20, 8'h5A, 8'h5A, 8'hA5, 1, 5, 1'b0};
        vt[4] = '{1'b0, 8'hFF, 20, 8'hFF, 8'hA5, 8'h00, 1, 5, 1'b0};
        vt[5] = '{1'b0, 8'h00, 20, 8'h00, 8'h00, 8'hFF, 1, 5, 1'b1};
        vt[6] = '{1'b1, 8'hFF,  1, 8'h00, 8'h00, 8'h00, 0, 0, 1'b1};
        vt[7] = '{1'b0, 8'hFF, 20, 8'hFF, 8'hFF, 8'h00, 1, 5, 1'b0};
        vt[8] = '{1'b1, 8'h00,  2, 8'h00, 8'h00, 8'h00, 0, 0, 1'b1};

        for (int j = 0; j < 9; j++) begin
            rst_a = vt[j].rst;
            sw_a  = vt[j].sw;
            acc_r = '0; acc_f = '0; n_chg = 0; n_tick = 0;
            for (int c = 0; c < vt[j].cycles; c++) begin
                @(negedge clk);
                acc_r |= rise_a;
                acc_f |= fall_a;
                n_chg += int'(chg_a);
                n_tick += int'(tick_a);
            end
            check($sformatf("vec%0d_sw_out", j), 32'(out_a), 32'(vt[j].exp_out));
            check($sformatf("vec%0d_rise", j), 32'(acc_r), 32'(vt[j].exp_rise));
            check($sformatf("vec%0d_fall", j), 32'(acc_f), 32'(vt[j].exp_fall));
            check($sformatf("vec%0d_changed", j), 32'(n_chg), 32'(vt[j].exp_chg));
            check($sformatf("vec%0d_ticks", j), 32'(n_tick), 32'(vt[j].exp_ticks));
            check($sformatf("vec%0d_zero", j), 32'(zero_a), 32'(vt[j].exp_zero));
        end

        // Bounce on bit0 short enough to span at most two ticks is rejected.
        rst_a = 1'b0; sw_a = 8'h00;
        repeat (10) @(negedge clk);
        sw_a = 8'h01;
        repeat (6) @(negedge clk);
        sw_a = 8'h00;
        n_chg = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_chg += int'(chg_a);
        end
        check("bounce_changed", 32'(n_chg), 32'd0);
        check("bounce_sw_out", 32'(out_a), 32'h00);
        sw_a = 8'h01;
        e = 0;
        while (e < 40 && out_a[0] !== 1'b1) begin
            @(negedge clk);
            e++;
        end
        check("hold_latency_in_range", 32'(e >= 11 && e <= 15), 32'd1);
        check("hold_rise", 32'(rise_a), 32'h01);

        // Reset on the second differing tick discards the partial count.
        rst_a = 1'b1; sw_a = 8'h00;
        @(negedge clk);
        rst_a = 1'b0;
        repeat (10) @(negedge clk);
        sw_a = 8'hFF;
        repeat (2) @(negedge clk);
        nt = 0;
        for (int g = 0; g < 20 && nt < 2; g++) begin
            if (tick_a) nt++;
            if (nt < 2) @(negedge clk);
        end
        check("midreset_ticks_seen", 32'(nt), 32'd2);
        rst_a = 1'b1;
        @(negedge clk);
        check("midreset_sw_out", 32'(out_a), 32'h00);
        check("midreset_tick", 32'(tick_a), 32'd0);
        rst_a = 1'b0;
        e = 0;
        while (e < 30 && out_a !== 8'hFF) begin
            @(negedge clk);
            e++;
        end
        check("midreset_latency", 32'(e), 32'd13);

        // Randomized traffic with occasional resets; the model checks every cycle.
        cyc = 0;
        while (cyc < 3000) begin
            if ($urandom_range(0, 29) == 0) begin
                rst_a = 1'b1;
                @(negedge clk);
                rst_a = 1'b0;
                cyc++;
            end else begin
                if ($urandom_range(0, 1) == 0) sw_a = 8'($urandom);
                else sw_a = sw_a ^ (8'h01 << $urandom_range(0, 7));
                hold = $urandom_range(1, 20);
                repeat (hold) @(negedge clk);
                cyc += hold;
            end
        end

        // SAMPLE_DIV=1, STABLE_SAMPLES=1: tick always high, three-cycle latency.
        rst_b = 1'b1; sw_b = 8'h00;
        repeat (2) @(negedge clk);
        check("b_reset_zero", 32'(zero_b), 32'd1);
        check("b_reset_tick", 32'(tick_b), 32'd0);
        rst_b = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("b_tick_held", 32'(tick_b), 32'd1);
        end
        prev = 8'h00;
        for (int j = 0; j < 6; j++) begin
            v = 8'($urandom);
            if (v == prev) v = ~prev;
            sw_b = v;
            repeat (2) begin
                @(negedge clk);
                check("b_sw_out_early", 32'(out_b), 32'(prev));
                check("b_changed_early", 32'(chg_b), 32'd0);
            end
            @(negedge clk);
            check("b_sw_out", 32'(out_b), 32'(v));
            check("b_rise", 32'(rise_b), 32'(v & ~prev));
            check("b_fall", 32'(fall_b), 32'(~v & prev));
            check("b_changed", 32'(chg_b), 32'd1);
            check("b_zero", 32'(zero_b), 32'(v == 8'h00));
            check("b_tick", 32'(tick_b), 32'd1);
            @(negedge clk);
            check("b_changed_after", 32'(chg_b), 32'd0);
            prev = v;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
